// File: rtl/mat_mult_loader.sv
// Load-then-run front end for the 3x3 matrix-multiply core: streams A and B into
// data memory row-major, then steps the core's pc from -4 up to the halt address.
module mat_mult_loader #(
   parameter int DW      = 32,
   parameter int N       = 3,
   parameter int BASE_A  = 0,
   parameter int BASE_B  = 36,
   parameter int HALT_PC = 356
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [31:0]   mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [31:0]   pc,
   output logic          running,
   output logic          halted
);

   localparam int            NE      = N * N;
   localparam int            CW      = (NE > 1) ? $clog2(NE) : 1;
   localparam logic [CW-1:0] LAST    = CW'(NE - 1);
   localparam logic [31:0]   PC_INIT = 32'hFFFF_FFFC;
   localparam logic [31:0]   A_BASE  = 32'(BASE_A);
   localparam logic [31:0]   B_BASE  = 32'(BASE_B);
   localparam logic [31:0]   PC_STOP = 32'(HALT_PC);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      RUN,
      HALT
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;

   assign accept = in_valid & in_ready;

   // Byte address of element idx within a matrix starting at base.
   function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                             input logic [CW-1:0] idx);
      return base + {{(30 - CW){1'b0}}, idx, 2'b00};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         pc        <= PC_INIT;
         running   <= 1'b0;
         halted    <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD_A;
                  cnt      <= '0;
                  in_ready <= 1'b1;
               end
            end

            LOAD_A: begin
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= elem_addr(A_BASE, cnt);
                  mem_wdata <= in_data;
                  if (cnt == LAST) begin
                     state <= LOAD_B;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

            // The last B write lands in the first RUN cycle while pc is still -4.
            LOAD_B: begin
               if (accept) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= elem_addr(B_BASE, cnt);
                  mem_wdata <= in_data;
                  if (cnt == LAST) begin
                     state    <= RUN;
                     cnt      <= '0;
                     in_ready <= 1'b0;
                     running  <= 1'b1;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

            RUN: begin
               pc <= pc + 32'd4;
               if (pc + 32'd4 == PC_STOP) begin
                  state   <= HALT;
                  running <= 1'b0;
                  halted  <= 1'b1;
               end
            end

            HALT: begin
               if (start) begin
                  state    <= LOAD_A;
                  cnt      <= '0;
                  pc       <= PC_INIT;
                  halted   <= 1'b0;
                  in_ready <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_mult_loader.sv
// Directed bench for mat_mult_loader: expected memory writes are queued as beats
// are driven and matched cycle-exactly against mem_we/mem_addr/mem_wdata.
module tb_mat_mult_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] pc;
   logic        running;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          stamp;
   } wr_t;

   wr_t q[$];

   mat_mult_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .pc        (pc),
      .running   (running),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Write monitor: a write is expected exactly in the cycle stamped at push time.
   always @(posedge clk) begin
      #1;
      begin
         logic exp_we;
         wr_t  w;
         exp_we = (q.size() > 0) && (q[0].stamp == cyc);
         chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
         if (exp_we) begin
            w = q.pop_front();
            chk("mem_addr", mem_addr, w.addr);
            chk("mem_wdata", mem_wdata, w.data);
         end
      end
   end

   task automatic beat(input logic [31:0] d, input logic [31:0] exp_addr, input logic st);
      wr_t w;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      start    = st;
      chk("in_ready", {31'b0, in_ready}, 32'd1);
      w.addr  = exp_addr;
      w.data  = d;
      w.stamp = cyc + 1;
      q.push_back(w);
   endtask

   task automatic gap();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
      chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_pc"}, pc, 32'hFFFF_FFFC);
      chk({tag, "_running"}, {31'b0, running}, 32'd0);
      chk({tag, "_halted"}, {31'b0, halted}, 32'd0);
   endtask

   initial begin
      rst_n    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;

      // Asynchronous reset applied between clock edges.
      #3 rst_n = 1'b0;
      #1 chk_reset_vals("rst_async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {31'b0, in_ready}, 32'd0);

      // Continuous load A=1..9, B=10..18; start pulsed during LOAD_B must be ignored.
      pulse_start();
      for (int i = 0; i < 9; i++) beat(32'(i + 1), 32'(4 * i), 1'b0);
      for (int i = 0; i < 9; i++) beat(32'(i + 10), 32'(36 + 4 * i), (i == 3));
      gap();
      chk("run_entered", {31'b0, running}, 32'd1);
      chk("run_in_ready", {31'b0, in_ready}, 32'd0);
      chk("run_first_pc", pc, 32'hFFFF_FFFC);

      // pc steps 0..356; start during RUN must not disturb it.
      for (int i = 0; i < 90; i++) begin
         @(negedge clk);
         start = (i == 40);
         chk("pc_step", pc, 32'(4 * i));
         if (i < 89) chk("running_hi", {31'b0, running}, 32'd1);
         else begin
            chk("halted_set", {31'b0, halted}, 32'd1);
            chk("running_lo", {31'b0, running}, 32'd0);
         end
      end
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("pc_hold", pc, 32'd356);
         chk("halted_hold", {31'b0, halted}, 32'd1);
      end

      // Restart from HALT with backpressure gaps (valid pattern 1,0,0).
      pulse_start();
      chk("restart_pc", pc, 32'hFFFF_FFFC);
      chk("restart_halted", {31'b0, halted}, 32'd0);
      chk("restart_in_ready", {31'b0, in_ready}, 32'd1);
      for (int i = 0; i < 18; i++) begin
         beat(32'(100 + i), (i < 9) ? 32'(4 * i) : 32'(36 + 4 * (i - 9)), 1'b0);
         gap();
         gap();
      end
      chk("gap_queue_drained", 32'(q.size()), 32'd0);
      begin
         int budget = 0;
         while (!halted && budget < 200) begin
            @(negedge clk);
            budget++;
         end
      end
      chk("gap_run_halted", {31'b0, halted}, 32'd1);
      chk("gap_run_pc", pc, 32'd356);

      // Reset mid-load after beat 5, then reload from address 0.
      pulse_start();
      for (int i = 0; i < 5; i++) beat(32'(50 + i), 32'(4 * i), 1'b0);
      gap();
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_midload");
      @(negedge clk);
      rst_n = 1'b1;
      pulse_start();
      for (int i = 0; i < 3; i++) beat(32'(200 + i), 32'(4 * i), 1'b0);
      gap();
      gap();
      chk("reload_queue_drained", 32'(q.size()), 32'd0);
      chk("reload_in_ready", {31'b0, in_ready}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mat_mult_loader.md
Name: mat_mult_loader

Overview:
Synthesizable front-end for the 3x3 matrix-multiply MIPS core.
- Accepts the two operand matrices A and B as a valid/ready element stream and writes them row-major into the core's data memory.
- Then releases the core by generating its program counter: pc starts at -4 and steps +4 per clock until it reaches the halt address.
- Replaces the free-running pc stimulus with a handshaked, restartable load-then-run sequence.

Parameters:
DW, 32, data word width (element and memory data width)
N, 3, matrix dimension; each matrix has N*N elements
BASE_A, 0, byte address of A[0][0] in data memory
BASE_B, 36, byte address of B[0][0] in data memory
HALT_PC, 356, pc value at which stepping stops

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse: begin loading a new A/B pair
in_valid  input  1  in_data holds a valid element
in_data  input  DW  element value, A row-major first, then B row-major
in_ready  output  1  loader accepts an element this cycle
mem_we  output  1  data-memory write strobe
mem_addr  output  32  data-memory byte address
mem_wdata  output  DW  data-memory write data
pc  output  32  program counter driven to the core
running  output  1  core is executing (pc stepping)
halted  output  1  pc has reached HALT_PC; results are valid

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, element counter=0.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - pc=32'hFFFF_FFFC, running=0, halted=0.
- States: IDLE -> LOAD_A -> LOAD_B -> RUN -> HALT.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD_A, counter=0.
- LOAD_A / LOAD_B:
  - in_ready=1.
  - A beat is accepted when in_valid & in_ready.
  - On acceptance, registered write in the next cycle: mem_we=1, mem_addr=base+4*counter, mem_wdata=in_data.
  - base is BASE_A in LOAD_A and BASE_B in LOAD_B.
  - Write latency is exactly 1 cycle. mem_we=0 in every cycle not following an accepted beat.
  - Counter increments per accepted beat.
  - Counter=N*N-1 accepted in LOAD_A -> LOAD_B, counter=0.
  - Counter=N*N-1 accepted in LOAD_B -> RUN.
  - in_valid=0 stalls indefinitely with no write.
  - start is ignored during LOAD_A/LOAD_B.
- RUN:
  - in_ready=0, running=1.
  - pc increments by 4 on every clock, first value 0 (from -4).
  - When the incremented pc equals HALT_PC: -> HALT.
  - The final mem_we from LOAD_B occurs in the first RUN cycle, before pc reaches 4.
- HALT:
  - pc holds at HALT_PC, running=0, halted=1.
  - start=1 -> pc=-4, halted=0, counter=0, -> LOAD_A.
- Arithmetic: pc uses 32-bit wrap-around arithmetic (-4+4=0). mem_addr is a byte address (word index*4).
- start during RUN is ignored; the core is never interrupted except by rst_n.
- Reset mid-load discards the partial load. Memory contents are not cleared by the loader.

Test Plan:
- Reset: rst_n low mid-cycle -> all outputs at reset values immediately; pc=0xFFFFFFFC.
- Full load, continuous: start, then 18 beats with in_valid held high, A=1..9, B=10..18 -> writes addr 0..32 with data 1..9, then addr 36..68 with data 10..18, each 1 cycle after its beat; RUN entered after beat 18.
- Backpressure gaps: in_valid toggles 1,0,0,1 -> no mem_we in the gap cycles; addresses stay contiguous; element count still 18.
- PC run: after load, pc sequence 0,4,8,...,356 on consecutive clocks (90 values); running=1 throughout; then halted=1 and pc holds at 356 for 10+ cycles.
- Ignored start: pulse start during LOAD_B and during RUN -> no state or counter change.
- Restart/reset mid-op: start in HALT -> pc=-4, reload writes restart at addr 0. rst_n low after beat 5 -> IDLE; next start rewrites from addr 0.
